// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; training and the invalidation sweep happen on the rising edge.
module branch_target_buffer #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] lookup_pc,
  output logic        lookup_hit,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        flush_req,
  output logic        busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_clr_idx;
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_lk_hit;
  logic             w_up_hit;
  logic             w_up_en;
  logic [1:0]       w_up_ctr;
  logic [1:0]       w_ctr_next;
  logic             w_unused_pc_bits;

  assign w_lk_idx = lookup_pc[2 +: IDX_W];
  assign w_lk_tag = lookup_pc[31 : 2 + IDX_W];
  assign w_up_idx = update_pc[2 +: IDX_W];
  assign w_up_tag = update_pc[31 : 2 + IDX_W];
  assign w_unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookups read pre-update state, so a same-cycle update to the same index is not bypassed.
  assign w_lk_hit      = (r_state == READY) && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign lookup_hit    = w_lk_hit;
  assign lookup_taken  = w_lk_hit & r_ctr[w_lk_idx][1];
  assign lookup_target = w_lk_hit ? r_target[w_lk_idx] : 32'h0;
  assign busy          = (r_state == CLEAR);

  // A flush wins over a coincident update, and nothing trains while the sweep runs.
  assign w_up_en  = update_valid && (r_state == READY) && !flush_req && !RST;
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_ctr = r_ctr[w_up_idx];

  assign w_ctr_next = update_taken
                    ? ((w_up_ctr == 2'b11) ? 2'b11 : w_up_ctr + 2'b01)
                    : ((w_up_ctr == 2'b00) ? 2'b00 : w_up_ctr - 2'b01);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else if (r_state == CLEAR) begin
      r_valid[r_clr_idx] <= 1'b0;
      if (flush_req) begin
        r_clr_idx <= '0;
      end else if (r_clr_idx == LAST_IDX) begin
        r_state <= READY;
      end else begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
    end else begin
      if (flush_req) begin
        r_state   <= CLEAR;
        r_clr_idx <= '0;
      end else if (w_up_en && !w_up_hit && update_taken) begin
        r_valid[w_up_idx] <= 1'b1;
      end
    end
  end

  // NOTE: the payload arrays have no reset; the valid sweep alone makes stale contents invisible.
  always_ff @(posedge CLK) begin
    if (w_up_en) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_next;
        if (update_taken) begin
          r_target[w_up_idx] <= update_target;
        end
      end else if (update_taken) begin
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= update_target;
        r_ctr[w_up_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus random traffic,
// compared every cycle against an entry-level model of the predictor.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;

  logic        CLK;
  logic        RST;
  logic [31:0] lookup_pc;
  logic        lookup_hit;
  logic        lookup_taken;
  logic [31:0] lookup_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        flush_req;
  logic        busy;

  branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .lookup_pc    (lookup_pc),
    .lookup_hit   (lookup_hit),
    .lookup_taken (lookup_taken),
    .lookup_target(lookup_target),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_target(update_target),
    .update_taken (update_taken),
    .flush_req    (flush_req),
    .busy         (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: one record per entry, plus the number of sweep cycles still to run.
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int          m_sweep_left = ENTRIES;
  bit          m_known      = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_check(input logic [31:0] lpc);
    int          i;
    bit          e_hit;
    bit          e_taken;
    logic [31:0] e_tgt;
    i       = idx_of(lpc);
    e_hit   = (m_sweep_left == 0) && m_valid[i] && (m_tag[i] == tag_of(lpc));
    e_taken = e_hit && (m_ctr[i] >= 2);
    e_tgt   = e_hit ? m_target[i] : 32'h0;
    check("busy",   {31'b0, busy},         {31'b0, m_sweep_left > 0});
    check("hit",    {31'b0, lookup_hit},   {31'b0, e_hit});
    check("taken",  {31'b0, lookup_taken}, {31'b0, e_taken});
    check("target", lookup_target,         e_tgt);
  endtask

  task automatic model_edge(input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                            input logic utk, input logic fl, input logic rs);
    int i;
    i = idx_of(upc);
    if (rs || fl) begin
      m_sweep_left = ENTRIES;
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
      if (rs) m_known = 1'b1;
    end else if (m_sweep_left > 0) begin
      m_sweep_left--;
    end else if (uv) begin
      if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
        m_ctr[i] = utk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (utk) m_target[i] = utgt;
      end else if (utk) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upc);
        m_target[i] = utgt;
        m_ctr[i]    = 2;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, advance across the rising edge.
  task automatic cyc(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                     input logic [31:0] utgt, input logic utk, input logic fl, input logic rs);
    lookup_pc     = lpc;
    update_valid  = uv;
    update_pc     = upc;
    update_target = utgt;
    update_taken  = utk;
    flush_req     = fl;
    RST           = rs;
    #1;
    if (m_known) model_check(lpc);
    @(posedge CLK);
    model_edge(uv, upc, utgt, utk, fl, rs);
    @(negedge CLK);
  endtask

  task automatic idle(input logic [31:0] lpc);
    cyc(lpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    cyc(pc, 1'b1, pc, tgt, tk, 1'b0, 1'b0);
  endtask

  // Lookup without a clock edge, compared against constants from the scenario.
  task automatic peek(input string tag, input logic [31:0] pc, input logic e_hit,
                      input logic e_taken, input logic [31:0] e_tgt);
    lookup_pc    = pc;
    update_valid = 1'b0;
    flush_req    = 1'b0;
    RST          = 1'b0;
    #1;
    check({tag, "_hit"},    {31'b0, lookup_hit},   {31'b0, e_hit});
    check({tag, "_taken"},  {31'b0, lookup_taken}, {31'b0, e_taken});
    check({tag, "_target"}, lookup_target,         e_tgt);
  endtask

  // Counts cycles with busy high (bounded); optionally fires taken updates meanwhile.
  task automatic count_busy(input string tag, input bit with_updates);
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!busy) break;
      n++;
      if (with_updates) upd(32'h240 + 32'(k % 4) * 4, 1'b1, 32'hABC0 + 32'(k));
      else idle(32'h100);
    end
    check(tag, 32'(n), 32'd16);
  endtask

  initial begin
    lookup_pc = '0; update_valid = 1'b0; update_pc = '0; update_target = '0;
    update_taken = 1'b0; flush_req = 1'b0; RST = 1'b1;
    @(negedge CLK);

    // T1: reset, sweep length, everything misses after
    cyc(32'h100, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    count_busy("t1_busy_len", 1'b0);
    peek("t1_miss", 32'h100, 1'b0, 1'b0, 32'h0);

    // T2: allocate and read back
    upd(32'h100, 1'b1, 32'h200);
    peek("t2_hit", 32'h100, 1'b1, 1'b1, 32'h200);
    peek("t2_other_tag", 32'h140, 1'b0, 1'b0, 32'h0);

    // T3: counter saturation in both directions
    repeat (3) upd(32'h100, 1'b1, 32'h200);
    peek("t3_strong", 32'h100, 1'b1, 1'b1, 32'h200);
    repeat (4) upd(32'h100, 1'b0, 32'hDEAD);
    peek("t3_nt_floor", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b1, 32'h300);
    peek("t3_weak_nt", 32'h100, 1'b1, 1'b0, 32'h300);

    // T4: not-taken miss allocates nothing; taken miss evicts
    upd(32'h180, 1'b0, 32'h999);
    peek("t4_no_alloc", 32'h180, 1'b0, 1'b0, 32'h0);
    upd(32'h140, 1'b1, 32'h444);
    peek("t4_evicted", 32'h100, 1'b0, 1'b0, 32'h0);
    peek("t4_new", 32'h140, 1'b1, 1'b1, 32'h444);

    // T5: flush drops the coincident update; a second flush restarts the sweep
    cyc(32'h1C0, 1'b1, 32'h1C4, 32'h555, 1'b1, 1'b1, 1'b0);
    count_busy("t5_busy_len", 1'b0);
    peek("t5_dropped", 32'h1C4, 1'b0, 1'b0, 32'h0);
    peek("t5_flushed", 32'h140, 1'b0, 1'b0, 32'h0);
    cyc(32'h0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    repeat (10) idle(32'h0);
    cyc(32'h0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    count_busy("t5_reflush_len", 1'b0);

    // T6: reset mid-sweep restarts it; updates during the sweep are ignored
    upd(32'h244, 1'b1, 32'h777);
    cyc(32'h0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    repeat (5) idle(32'h0);
    cyc(32'h0, 1'b1, 32'h240, 32'h888, 1'b1, 1'b0, 1'b1);
    count_busy("t6_busy_len", 1'b1);
    peek("t6_no_train", 32'h240, 1'b0, 1'b0, 32'h0);
    peek("t6_swept", 32'h244, 1'b0, 1'b0, 32'h0);

    // Random traffic over a small PC pool so indices collide and tags alias
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] lpc, upc, tgt;
      logic        uv, tk, fl, rs;
      lpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      tgt = $urandom;
      uv  = ($urandom_range(0, 99) < 60);
      tk  = ($urandom_range(0, 99) < 60);
      fl  = ($urandom_range(0, 99) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      cyc(lpc, uv, upc, tgt, tk, fl, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
